booth_datapath: RTL and testbench
=================================

Name: booth_datapath

Overview:
- Arithmetic end of the radix-2 Booth multiplier. It consumes the per-step add/sub/nop command stream from the Booth control unit.
- Holds the multiplicand and accumulates the partial product. After every command it performs the Booth arithmetic right shift.
- After WIDTH accepted commands it presents the signed 2*WIDTH-bit product with a one-cycle done pulse.
- Sits between the operand registers and the multiplier result register in the EX stage.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  load multiplicand, clear accumulator, begin a new multiply
multiplicand  input  WIDTH  signed multiplicand M, sampled only on the start cycle
op_valid  input  1  op carries a valid Booth command this cycle
op  input  2  Booth command: 00 nop, 01 add M, 10 sub M, 11 nop
op_ready  output  1  datapath accepts a command this cycle
busy  output  1  multiply in progress
done  output  1  one-cycle pulse, product valid
product  output  2*WIDTH  signed product, held until next start or rst

Behaviour:
- Reset (rst=1 at clk edge) applies in any state, including mid-run. Result: state IDLE, A=0, Q=0, M=0, cnt=0, op_ready=0, busy=0, done=0, product=0.
- Registers:
  - A is WIDTH+1 bits, signed. The extra bit absorbs the add/sub of -2^(WIDTH-1).
  - Q is WIDTH bits and receives the shifted-out low product bits.
  - M is WIDTH bits.
  - cnt is clog2(WIDTH)+1 bits.
- States: IDLE, RUN, DONE.
- IDLE: op_ready=0, busy=0. On start: M<=multiplicand, A<=0, Q<=0, cnt<=0, go to RUN.
- RUN: op_ready=1, busy=1.
  - A command is accepted when op_valid=1 and op_ready=1.
  - op_valid=0 is a stall: no register changes.
- Per accepted command, all in one cycle:
  - T = A + sext(M) for 01; A - sext(M) for 10; A for 00/11.
  - Then {A,Q} <= {T,Q} >>> 1 (arithmetic): Q <= {T[0], Q[WIDTH-1:1]}, A <= T >>> 1.
  - cnt <= cnt+1.
- When the accepted command is number WIDTH (cnt==WIDTH-1 at acceptance):
  - product <= {T>>>1 low WIDTH bits, T[0], Q[WIDTH-1:1]}, i.e. the final {A[WIDTH-1:0],Q}.
  - Go to DONE.
- Latency: product valid and done=1 in the cycle after the WIDTH-th command is accepted. Minimum is WIDTH+1 cycles from the start cycle.
- DONE: done=1 for exactly one cycle, busy=0, op_ready=0. Then go to IDLE; product is held.
- op_valid in IDLE or DONE: ignored, no state change.
- start in RUN or DONE aborts the current multiply and reloads as from IDLE. A start with op_valid in the same cycle: start wins and the op is discarded. done is not asserted for the aborted run.
- rst and start in the same cycle: rst wins.
- No overflow is possible. Signed WIDTH x WIDTH always fits in 2*WIDTH, including (-2^15)*(-2^15) = 0x40000000.

Test Plan:
- Basic multiply: rst, then start with M=3. Commands (LSB-first Booth pairs of multiplier 5): 10,01,10,01, then 12x 00, op_valid=1 every cycle. Required: done pulses in the cycle after the 16th command; product=0x0000000F; busy low after done.
- Negative multiplier: M=7, commands 10 then 15x 11 (multiplier 0xFFFF). Required: product=0xFFFFFFF9; 11 behaves exactly as 00.
- Extreme operands: M=0x8000, commands 15x 00 then 10 (multiplier 0x8000). Required: product=0x40000000 with no sign corruption in A.
- Stalls: M=-3 (0xFFFD), multiplier 5 sequence as in the basic test, with op_valid randomly low about 50%. Required: product=0xFFFFFFF1; done only after the 16th accepted command; state frozen during stalls.
- Abort/restart: start, accept 6 commands, then start with M=2 in the same cycle as op_valid. Feed the multiplier-5 sequence. Required: no done for the first run; product=0x0000000A.
- Reset mid-run: assert rst after 9 accepted commands. Required next cycle: all outputs 0, op_ready=0. Commands ignored until start; a following full multiply is correct.

Source files
------------

// File: rtl/booth_datapath_if.sv
//----------------------------------------------------------------------------
// Module  : booth_datapath_if
// Brief   : Command/result bundle between the Booth control unit and datapath.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

interface booth_datapath_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic                   op_valid;
    logic [1:0]             op;
    logic                   op_ready;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, multiplicand, op_valid, op,
        input  op_ready, busy, done, product
    );

    modport slave (
        input  start, multiplicand, op_valid, op,
        output op_ready, busy, done, product
    );
endinterface

`default_nettype wire

// File: rtl/booth_datapath.sv
//----------------------------------------------------------------------------
// Module  : booth_datapath
// Brief   : Radix-2 Booth accumulate/shift datapath producing a signed product.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module booth_datapath #(
    parameter int WIDTH = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    booth_datapath_if.slave     bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic signed [WIDTH:0]  r_a;
    logic [WIDTH-1:0]       r_q;
    logic [WIDTH-1:0]       r_m;
    logic [CW-1:0]          r_cnt;
    logic                   r_op_ready;
    logic                   r_busy;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_product;

    logic signed [WIDTH:0]  w_msext;
    logic signed [WIDTH:0]  w_t;
    logic signed [WIDTH:0]  w_a_next;
    logic [WIDTH-1:0]       w_q_next;
    logic                   w_accept;
    logic                   w_last;

    // A carries one guard bit so that +/- (-2^(WIDTH-1)) never wraps.
    always_comb begin
        w_msext = {r_m[WIDTH-1], r_m};
        case (bus.op)
            2'b01:   w_t = r_a + w_msext;
            2'b10:   w_t = r_a - w_msext;
            default: w_t = r_a;
        endcase
        w_a_next = w_t >>> 1;
        w_q_next = {w_t[0], r_q[WIDTH-1:1]};
        w_accept = (r_state == S_RUN) && bus.op_valid;
        w_last   = (r_cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_q        <= '0;
            r_m        <= '0;
            r_cnt      <= '0;
            r_op_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_product  <= '0;
        end else if (bus.start) begin
            // A start in any state reloads; a concurrent command is dropped.
            r_state    <= S_RUN;
            r_m        <= bus.multiplicand;
            r_a        <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_op_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_a   <= w_a_next;
                        r_q   <= w_q_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_product  <= {w_a_next[WIDTH-1:0], w_q_next};
                            r_state    <= S_DONE;
                            r_op_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready = r_op_ready;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.product  = r_product;

endmodule

`default_nettype wire

// File: tb/tb_booth_datapath.sv
//----------------------------------------------------------------------------
// Module  : tb_booth_datapath
// Brief   : Directed, self-checking bench for booth_datapath.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_booth_datapath;
    localparam int W = 16;
    localparam logic [31:0] CMD_MUL5    = 32'h0000_0066;
    localparam logic [31:0] CMD_MULFFFF = 32'hFFFF_FFFE;
    localparam logic [31:0] CMD_MUL8000 = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    booth_datapath_if #(.WIDTH(W)) bus ();

    booth_datapath #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: product = M * sum(d_k * 2^k) over accepted commands, d = +1/-1/0.
    bit          m_run;
    int          m_cnt;
    longint      m_M;
    longint      m_acc;
    logic        exp_ready, exp_busy, exp_done;
    logic [31:0] exp_prod;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_cnt = 0; m_M = 0; m_acc = 0;
            exp_ready = 0; exp_busy = 0; exp_done = 0; exp_prod = '0;
        end else if (bus.start) begin
            m_run = 1; m_cnt = 0; m_acc = 0;
            m_M = longint'($signed(bus.multiplicand));
            exp_ready = 1; exp_busy = 1; exp_done = 0;
        end else if (m_run) begin
            exp_done = 0;
            if (bus.op_valid) begin
                if (bus.op == 2'b01) m_acc = m_acc + (m_M <<< m_cnt);
                if (bus.op == 2'b10) m_acc = m_acc - (m_M <<< m_cnt);
                m_cnt++;
                if (m_cnt == W) begin
                    exp_prod  = m_acc[31:0];
                    m_run     = 0;
                    exp_ready = 0;
                    exp_busy  = 0;
                    exp_done  = 1;
                end
            end
        end else begin
            exp_done = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("op_ready", {31'd0, bus.op_ready}, {31'd0, exp_ready});
            chk("busy",     {31'd0, bus.busy},     {31'd0, exp_busy});
            chk("done",     {31'd0, bus.done},     {31'd0, exp_done});
            chk("product",  bus.product,           exp_prod);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_mul(input logic [15:0] m, input bit with_op);
        bus.start        = 1'b1;
        bus.multiplicand = m;
        bus.op_valid     = with_op;
        bus.op           = 2'b01;
        step();
        bus.start        = 1'b0;
        bus.multiplicand = 16'(($urandom));
        bus.op_valid     = 1'b0;
        bus.op           = 2'b00;
    endtask

    task automatic feed(input logic [31:0] cmds, input int n, input bit stall);
        int k     = 0;
        int guard = 0;
        while (k < n && guard < 200) begin
            bus.op_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.op       = bus.op_valid ? cmds[2*k +: 2] : 2'($urandom);
            step();
            if (bus.op_valid) k++;
            guard++;
        end
        bus.op_valid = 1'b0;
        bus.op       = 2'b00;
        if (k < n) begin
            n_vec++;
            n_fail++;
            $display("FAIL feed_timeout: got %0d accepted expected %0d", k, n);
        end
    endtask

    task automatic finish_check(input string name, input logic [31:0] lit);
        chk({name, "_done"},    {31'd0, bus.done}, 32'd1);
        chk({name, "_product"}, bus.product, lit);
        step();
        chk({name, "_done_clr"}, {31'd0, bus.done}, 32'd0);
        chk({name, "_idle"},     {31'd0, bus.busy}, 32'd0);
        chk({name, "_hold"},     bus.product, lit);
    endtask

    initial begin
        bus.start = 1'b0; bus.multiplicand = '0; bus.op_valid = 1'b0; bus.op = 2'b00;
        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_busy",    {31'd0, bus.busy},     32'd0);
        chk("rst_ready",   {31'd0, bus.op_ready}, 32'd0);
        chk("rst_product", bus.product,           32'd0);
        rst = 1'b0;
        step();

        // 3 * 5
        start_mul(16'd3, 1'b0);
        chk("run_busy", {31'd0, bus.busy}, 32'd1);
        feed(CMD_MUL5, 16, 1'b0);
        finish_check("basic", 32'h0000_000F);

        // 7 * -1 using 11 as a nop
        start_mul(16'd7, 1'b0);
        feed(CMD_MULFFFF, 16, 1'b0);
        finish_check("negmul", 32'hFFFF_FFF9);

        // (-2^15) * (-2^15)
        start_mul(16'h8000, 1'b0);
        feed(CMD_MUL8000, 16, 1'b0);
        finish_check("extreme", 32'h4000_0000);

        // -3 * 5 with random stalls
        start_mul(16'hFFFD, 1'b0);
        feed(CMD_MUL5, 16, 1'b1);
        finish_check("stall", 32'hFFFF_FFF1);

        // abort after 6 commands; restart carries a discarded op
        start_mul(16'd9, 1'b0);
        feed(CMD_MUL5, 6, 1'b0);
        start_mul(16'd2, 1'b1);
        chk("abort_nodone", {31'd0, bus.done}, 32'd0);
        feed(CMD_MUL5, 16, 1'b0);
        finish_check("abort", 32'h0000_000A);

        // reset after 9 accepted commands
        start_mul(16'd5, 1'b0);
        feed(CMD_MUL5, 9, 1'b0);
        rst = 1'b1; bus.op_valid = 1'b1; bus.op = 2'b01;
        step();
        rst = 1'b0;
        chk("midrst_ready",   {31'd0, bus.op_ready}, 32'd0);
        chk("midrst_busy",    {31'd0, bus.busy},     32'd0);
        chk("midrst_done",    {31'd0, bus.done},     32'd0);
        chk("midrst_product", bus.product,           32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ignored_busy", {31'd0, bus.busy}, 32'd0);
        end
        bus.op_valid = 1'b0;
        start_mul(16'd3, 1'b0);
        feed(CMD_MUL5, 16, 1'b0);
        finish_check("post_rst", 32'h0000_000F);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
